fifo_spi_engine: RTL and testbench
==================================

# fifo_spi_engine

Command-execution stage that sits directly downstream of the command `fifo` (MCU-to-FPGA direction) and upstream of the result `fifo` (FPGA-to-MCU direction). It pops 16-bit command words, executes each one as an SPI mode-0 transaction or a control action, and pushes captured MISO bytes into the result FIFO. It runs entirely in the FIFOs' `out_clock` / `in_clock` domain, so there is no clock crossing inside this block.

## Interface
Parameters:
- `DIV_BITS`, 8: width of the SCK half-period divider register.

Ports:
- `clock`, in, 1: single clock for the block.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cmd_data`, in, 16: command word; connects to command FIFO `out_data`.
- `cmd_nempty`, in, 1: command FIFO has data; connects to `out_nempty`.
- `cmd_pop`, out, 1: one-cycle pop strobe; connects to `out_pop`.
- `res_data`, out, 16: result word; connects to result FIFO `in_data`.
- `res_shift`, out, 1: one-cycle push strobe; connects to `in_shift`.
- `res_full`, in, 1: result FIFO full; connects to `in_full`.
- `spi_sck`, out, 1: SPI clock; idles low.
- `spi_mosi`, out, 1: SPI data out, MSB first.
- `spi_miso`, in, 1: SPI data in.
- `spi_cs_n`, out, 1: chip select, active low.
- `busy`, out, 1: high whenever the state is not IDLE.
- `error`, out, 1: sticky flag, set when an unknown opcode is received.

## Operation
- Command word layout: `[15:8]` opcode, `[7:0]` argument `arg`.
- Opcodes:
  - 0x00 NOP: no action.
  - 0x01 CS_LOW: `spi_cs_n` goes to 0.
  - 0x02 CS_HIGH: `spi_cs_n` goes to 1.
  - 0x03 XFER: shift `arg` out on MOSI and push `{8'h03, rx_byte}` to the result FIFO.
  - 0x04 WRITE: shift `arg` out; no push.
  - 0x05 SET_DIV: `div <= arg[DIV_BITS-1:0]`.
  - 0x06 DELAY: idle for `arg` cycles.
  - Any other opcode: sets `error`, otherwise behaves as NOP. Only reset clears `error`.
- The `spi_cs_n` level is fully software-controlled; XFER and WRITE never touch it.
- States: IDLE, EXEC, SCK_LO, SCK_HI, DELAY.
- IDLE:
  - If `cmd_nempty`, latch `cmd_data`, pulse `cmd_pop` for that cycle, and go to EXEC.
  - `cmd_nempty` is sampled in IDLE only.
- EXEC decodes the latched word:
  - Control opcodes take effect at the end of this cycle, then the state returns to IDLE.
  - DELAY: load the counter with `arg`. If `arg == 0`, go to IDLE; otherwise go to DELAY, count down to 1, then go to IDLE.
  - XFER while `res_full == 1`: stay in EXEC, with no SCK activity, until `res_full == 0`.
  - WRITE, or XFER with `res_full == 0`: load the shift register with `arg`, drive `spi_mosi <= arg[7]`, clear the bit counter, load the tick counter with `div`, and go to SCK_LO.
- SCK_LO:
  - Stays `div+1` cycles.
  - On exit: `spi_sck <= 1`, MISO is sampled into the shift-register LSB path, the tick counter reloads, and the state goes to SCK_HI.
- SCK_HI:
  - Stays `div+1` cycles.
  - On exit: `spi_sck <= 0`.
  - If bit 7 of the transfer is done: for XFER, pulse `res_shift` with `res_data = {8'h03, rx}`; go to IDLE.
  - Otherwise: shift, drive the next MOSI bit, increment the bit counter, and go to SCK_LO.
- Because only this block pushes to the result FIFO, `res_full == 0` at the start of an XFER guarantees the push succeeds.

## Timing
- Reset values (asynchronous, applied immediately):
  - State is IDLE.
  - `spi_cs_n = 1`; `spi_sck = 0`; `spi_mosi = 0`.
  - `cmd_pop = 0`; `res_shift = 0`; `res_data = 0`.
  - `div = 0`; `busy = 0`; `error = 0`.
- Reset mid-transfer aborts the transfer: the popped command is discarded and no partial result is pushed.
- `cmd_pop` is a single-cycle pulse. After a pop, the next `cmd_data`/`cmd_nempty` values are valid on the following cycle. The IDLE→EXEC→IDLE sequence guarantees this, since `cmd_nempty` is never resampled on the cycle immediately after a pop.
- Command cost, measured from the IDLE cycle that pops:
  - Control commands: 2 cycles.
  - DELAY `n`: `2 + n` cycles.
  - XFER/WRITE: `2 + 16*(div+1)` cycles, plus any cycles stalled on `res_full`.
- The SCK period is `2*(div+1)` clocks:
  - MOSI changes only on the falling SCK edge, or when the transfer starts.
  - MISO is registered on the same clock edge that raises SCK.
- `res_shift` is asserted on the same edge that produces the final falling SCK edge.
- Empty command FIFO: the block remains in IDLE with `busy = 0`.

## Test plan
- Reset, then commands 0x0100, 0x03A5, 0x0200 with MISO looping back MOSI:
  - `spi_cs_n` falls, exactly 8 SCK pulses occur, MOSI carries 1,0,1,0,0,1,0,1, and `spi_cs_n` rises.
  - Exactly one push of 0x03A5, with `res_shift` high for 1 cycle.
- Commands 0x0503, 0x0400 with `div = 3`:
  - SCK is high for 4 clocks and low for 4 clocks.
  - The byte lasts 64 clocks.
  - No `res_shift`.
- Command 0x033C with `res_full` held high for 20 cycles:
  - SCK stays idle for those 20 cycles.
  - After `res_full` falls, the transfer runs and pushes `{0x03, miso_byte}`.
- Commands 0x060A then 0x0000:
  - `busy` is high for 12 cycles after the pop of 0x060A.
  - The NOP is popped afterwards.
  - `error` stays 0.
- Command 0x7F00:
  - `error` rises and stays 1 through subsequent valid commands.
  - Only `reset_n` low clears it.
- Assert `reset_n = 0` during bit 4 of an XFER:
  - `spi_cs_n = 1`, `spi_sck = 0` and `busy = 0` immediately.
  - No `res_shift` pulse occurs.
  - After release, the next queued command executes normally.

Source files
------------

// File: rtl/fifo_spi_engine.sv
// fifo_spi_engine: pops 16-bit commands, runs them as SPI mode-0 byte transfers or
// control actions, and pushes captured MISO bytes to the result FIFO.
module fifo_spi_engine #(
    parameter int DIV_BITS = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] cmd_data,
    input  logic        cmd_nempty,
    output logic        cmd_pop,
    output logic [15:0] res_data,
    output logic        res_shift,
    input  logic        res_full,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        busy,
    output logic        error
);
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_SCK_LO, S_SCK_HI, S_DELAY} state_t;

    state_t                r_state, w_next;
    logic [15:0]           r_cmd, r_res_data;
    logic [DIV_BITS-1:0]   r_div, r_tick;
    logic [7:0]            r_shreg, r_dly;
    logic [2:0]            r_bit;
    logic                  r_sck, r_mosi, r_cs_n, r_err, r_res_shift;
    logic [7:0]            w_op, w_arg;
    logic                  w_start, w_tick_done, w_last;

    assign w_op        = r_cmd[15:8];
    assign w_arg       = r_cmd[7:0];
    // XFER only starts once the result FIFO has room, so its push can never be lost
    assign w_start     = (r_state == S_EXEC) && (w_op == 8'h04 || (w_op == 8'h03 && !res_full));
    assign w_tick_done = (r_tick == '0);
    assign w_last      = (r_bit == 3'd7);

    // gated by reset so a held reset never drains the command FIFO
    assign cmd_pop   = reset_n && (r_state == S_IDLE) && cmd_nempty;
    assign busy      = (r_state != S_IDLE);
    assign res_data  = r_res_data;
    assign res_shift = r_res_shift;
    assign spi_sck   = r_sck;
    assign spi_mosi  = r_mosi;
    assign spi_cs_n  = r_cs_n;
    assign error     = r_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = cmd_nempty ? S_EXEC : S_IDLE;
            S_EXEC:   w_next = w_start ? S_SCK_LO :
                               (w_op == 8'h03) ? S_EXEC :
                               (w_op == 8'h06 && w_arg != 8'd0) ? S_DELAY : S_IDLE;
            S_SCK_LO: w_next = w_tick_done ? S_SCK_HI : S_SCK_LO;
            S_SCK_HI: w_next = !w_tick_done ? S_SCK_HI : w_last ? S_IDLE : S_SCK_LO;
            S_DELAY:  w_next = (r_dly == 8'd1) ? S_IDLE : S_DELAY;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd       <= '0;
            r_div       <= '0;
            r_tick      <= '0;
            r_shreg     <= '0;
            r_dly       <= '0;
            r_bit       <= '0;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_err       <= 1'b0;
            r_res_shift <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_res_shift <= 1'b0;
            case (r_state)
                S_IDLE: if (cmd_nempty) r_cmd <= cmd_data;
                S_EXEC: begin
                    case (w_op)
                        8'h00, 8'h03, 8'h04: ;
                        8'h01:   r_cs_n <= 1'b0;
                        8'h02:   r_cs_n <= 1'b1;
                        8'h05:   r_div  <= DIV_BITS'(w_arg);
                        8'h06:   r_dly  <= w_arg;
                        default: r_err  <= 1'b1;
                    endcase
                    if (w_start) begin
                        r_shreg <= w_arg;
                        r_mosi  <= w_arg[7];
                        r_bit   <= '0;
                        r_tick  <= r_div;
                    end
                end
                S_SCK_LO: begin
                    if (w_tick_done) begin
                        r_sck   <= 1'b1;
                        r_shreg <= {r_shreg[6:0], spi_miso};
                        r_tick  <= r_div;
                    end else begin
                        r_tick  <= r_tick - DIV_BITS'(1);
                    end
                end
                S_SCK_HI: begin
                    if (w_tick_done) begin
                        r_sck <= 1'b0;
                        if (w_last) begin
                            if (w_op == 8'h03) begin
                                r_res_shift <= 1'b1;
                                r_res_data  <= {8'h03, r_shreg};
                            end
                        end else begin
                            // shreg already holds the next outgoing bit in its MSB
                            r_mosi <= r_shreg[7];
                            r_bit  <= r_bit + 3'd1;
                            r_tick <= r_div;
                        end
                    end else begin
                        r_tick <= r_tick - DIV_BITS'(1);
                    end
                end
                S_DELAY: r_dly <= r_dly - 8'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_spi_engine.sv
// tb_fifo_spi_engine: drives fifo_spi_engine from a modelled command FIFO and scores result pushes.
module tb_fifo_spi_engine;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cmd_data = '0;
    logic        cmd_nempty = 1'b0;
    logic        cmd_pop;
    logic [15:0] res_data;
    logic        res_shift;
    logic        res_full = 1'b0;
    logic        spi_sck, spi_mosi, spi_miso, spi_cs_n, busy, error;

    logic        lb = 1'b1;
    logic [7:0]  pat = '0;
    int          base = 0;

    logic [15:0] cmd_q[$];
    logic [15:0] exp_q[$];
    int          pop_cyc[$];
    int          cyc = 0;

    int          n_cmp = 0, n_bad = 0;
    int          rises = 0, falls = 0, run = 0, hi_last = 0, lo_last = 0;
    int          cs_falls = 0, cs_rises = 0, n_pushes = 0;
    logic [7:0]  mosi_hist = '0;
    logic        prev_sck = 1'b0, prev_cs = 1'b1, prev_rs = 1'b0;

    fifo_spi_engine #(.DIV_BITS(8)) dut (
        .clock(clock), .reset_n(reset_n), .cmd_data(cmd_data), .cmd_nempty(cmd_nempty),
        .cmd_pop(cmd_pop), .res_data(res_data), .res_shift(res_shift), .res_full(res_full),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n),
        .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    // slave model: loopback, or shift out pat MSB first, advancing on each falling SCK
    assign spi_miso = lb ? spi_mosi : pat[3'd7 - 3'(falls - base)];

    always @(posedge clock) begin
        cyc++;
        if (cmd_pop) begin
            pop_cyc.push_back(cyc);
            void'(cmd_q.pop_front());
        end
    end

    always @(negedge clock) begin
        cmd_nempty = (cmd_q.size() != 0);
        cmd_data   = (cmd_q.size() != 0) ? cmd_q[0] : 16'h0000;
    end

    always @(negedge clock) begin
        if (spi_sck !== prev_sck) begin
            if (spi_sck) begin
                rises++;
                mosi_hist = {mosi_hist[6:0], spi_mosi};
                lo_last = run;
            end else begin
                falls++;
                hi_last = run;
            end
            run = 1;
        end else run++;
        if (prev_cs && !spi_cs_n) cs_falls++;
        if (!prev_cs && spi_cs_n) cs_rises++;
        if (prev_rs) begin
            n_cmp++;
            if (res_shift !== 1'b0) begin
                n_bad++;
                $display("FAIL res_shift_width: res_shift=%b, required 0 one cycle after a push", res_shift);
            end
        end
        if (res_shift === 1'b1) begin
            n_pushes++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_push: res_data=%h, no push expected", res_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (res_data !== e) begin
                    n_bad++;
                    $display("FAIL push_data: res_data=%h, required %h", res_data, e);
                end
            end
        end
        prev_sck = spi_sck;
        prev_cs  = spi_cs_n;
        prev_rs  = res_shift;
    end

    task automatic wait_idle(input int max, output int nbusy);
        int c;
        c = 0;
        nbusy = 0;
        do begin
            @(negedge clock);
            c++;
            if (busy) nbusy++;
        end while ((busy || cmd_q.size() != 0) && c < max);
        @(negedge clock);
        n_cmp++;
        if (c >= max) begin
            n_bad++;
            $display("FAIL wait_idle: still busy after %0d cycles, limit %0d", c, max);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if (spi_cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
        n_cmp++; if (spi_sck !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b want 0", spi_sck); end
        n_cmp++; if (spi_mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
        n_cmp++; if ({cmd_pop, res_shift, res_data} !== 18'h0) begin
            n_bad++; $display("FAIL reset_fifo_side: pop=%b shift=%b data=%h want 0/0/0000", cmd_pop, res_shift, res_data);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL empty_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_xfer_loopback();
        int r0, p0, cf0, cr0, nb;
        lb = 1'b1;
        r0 = rises; p0 = n_pushes; cf0 = cs_falls; cr0 = cs_rises;
        exp_q.push_back(16'h03A5);
        cmd_q.push_back(16'h0100); cmd_q.push_back(16'h03A5); cmd_q.push_back(16'h0200);
        wait_idle(500, nb);
        n_cmp++; if (rises - r0 != 8) begin n_bad++; $display("FAIL xfer_sck_pulses: got %0d want 8", rises - r0); end
        n_cmp++; if (mosi_hist !== 8'hA5) begin n_bad++; $display("FAIL xfer_mosi_bits: got %h want a5", mosi_hist); end
        n_cmp++; if (cs_falls - cf0 != 1 || cs_rises - cr0 != 1) begin
            n_bad++; $display("FAIL xfer_cs_edges: falls %0d rises %0d, want 1/1", cs_falls - cf0, cs_rises - cr0);
        end
        n_cmp++; if (n_pushes - p0 != 1) begin n_bad++; $display("FAIL xfer_push_count: got %0d want 1", n_pushes - p0); end
        n_cmp++; if (nb != 19) begin n_bad++; $display("FAIL xfer_busy_cycles: got %0d want 19", nb); end
    endtask

    task automatic test_write_div();
        int r0, p0, nb;
        cmd_q.push_back(16'h0503);
        wait_idle(100, nb);
        r0 = rises; p0 = n_pushes;
        cmd_q.push_back(16'h0400);
        wait_idle(500, nb);
        n_cmp++; if (nb != 65) begin n_bad++; $display("FAIL write_busy_cycles: got %0d want 65", nb); end
        n_cmp++; if (rises - r0 != 8) begin n_bad++; $display("FAIL write_sck_pulses: got %0d want 8", rises - r0); end
        n_cmp++; if (hi_last != 4) begin n_bad++; $display("FAIL write_sck_high: got %0d want 4", hi_last); end
        n_cmp++; if (lo_last != 4) begin n_bad++; $display("FAIL write_sck_low: got %0d want 4", lo_last); end
        n_cmp++; if (n_pushes != p0) begin n_bad++; $display("FAIL write_no_push: got %0d pushes want 0", n_pushes - p0); end
    endtask

    task automatic test_res_full_stall();
        int r0, p0, c, hs, nb;
        lb = 1'b0; pat = 8'hC3; base = falls;
        res_full = 1'b1;
        exp_q.push_back(16'h03C3);
        cmd_q.push_back(16'h033C);
        c = 0;
        while (!busy && c < 20) begin @(negedge clock); c++; end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_start: busy=%b want 1", busy); end
        r0 = rises; p0 = n_pushes; hs = 0;
        repeat (20) begin @(negedge clock); if (spi_sck) hs++; end
        n_cmp++; if (hs != 0 || rises != r0) begin n_bad++; $display("FAIL stall_sck_idle: %0d high cycles, want 0", hs); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy: got %b want 1", busy); end
        res_full = 1'b0;
        wait_idle(500, nb);
        n_cmp++; if (rises - r0 != 8) begin n_bad++; $display("FAIL stall_sck_pulses: got %0d want 8", rises - r0); end
        n_cmp++; if (n_pushes - p0 != 1) begin n_bad++; $display("FAIL stall_push_count: got %0d want 1", n_pushes - p0); end
    endtask

    task automatic test_delay();
        int p0, nb, gap;
        p0 = pop_cyc.size();
        cmd_q.push_back(16'h060A); cmd_q.push_back(16'h0000);
        wait_idle(200, nb);
        gap = (pop_cyc.size() >= p0 + 2) ? pop_cyc[p0 + 1] - pop_cyc[p0] : -1;
        n_cmp++; if (nb != 12) begin n_bad++; $display("FAIL delay_busy_cycles: got %0d want 12", nb); end
        n_cmp++; if (gap != 12) begin n_bad++; $display("FAIL delay_pop_gap: got %0d want 12", gap); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL delay_error: got %b want 0", error); end
    endtask

    task automatic test_error_sticky();
        int nb;
        cmd_q.push_back(16'h7F00);
        wait_idle(100, nb);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL error_set: got %b want 1", error); end
        cmd_q.push_back(16'h0100); cmd_q.push_back(16'h0000); cmd_q.push_back(16'h0200);
        wait_idle(100, nb);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL error_sticky: got %b want 1", error); end
    endtask

    task automatic test_reset_mid_xfer();
        int r0, p0, c, nb;
        lb = 1'b1;
        r0 = rises; p0 = n_pushes;
        exp_q.push_back(16'h035A);
        cmd_q.push_back(16'h0100); cmd_q.push_back(16'h03F0); cmd_q.push_back(16'h035A);
        c = 0;
        while (rises < r0 + 5 && c < 1000) begin @(negedge clock); c++; end
        n_cmp++; if (rises < r0 + 5) begin n_bad++; $display("FAIL abort_reach_bit4: %0d pulses, want 5", rises - r0); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({spi_cs_n, spi_sck, busy} !== 3'b100) begin
            n_bad++; $display("FAIL abort_outputs: cs_n/sck/busy=%b%b%b want 100", spi_cs_n, spi_sck, busy);
        end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL abort_error_clear: got %b want 0", error); end
        repeat (3) @(negedge clock);
        n_cmp++; if (n_pushes != p0) begin n_bad++; $display("FAIL abort_no_push: got %0d pushes want 0", n_pushes - p0); end
        reset_n = 1'b1;
        wait_idle(500, nb);
        n_cmp++; if (nb != 17) begin n_bad++; $display("FAIL after_reset_busy: got %0d want 17", nb); end
        n_cmp++; if (n_pushes - p0 != 1) begin n_bad++; $display("FAIL after_reset_push: got %0d want 1", n_pushes - p0); end
        n_cmp++; if (spi_cs_n !== 1'b1) begin n_bad++; $display("FAIL after_reset_cs_n: got %b want 1", spi_cs_n); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL pending_pushes: %0d left, want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_xfer_loopback();
        test_write_div();
        test_res_full_stall();
        test_delay();
        test_error_sticky();
        test_reset_mid_xfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
